board_state_ctrl: RTL and testbench

- Owns the 10x10 board status array that drives the VGA grid renderer's cell_status_flat input.
- Serialises all board mutations from three requesters: a board clear, a ship placement and a shot.
  - Placement: bounds check, overlap scan, then a cell-by-cell write.
  - Shot: classification as miss, hit, repeat or invalid.
- Tracks remaining ship cells and raises game_over.
- Sits between the game-logic/input FSMs and the renderer, as a single-writer arbiter for board state.

---
 rtl/board_state_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_board_state_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_state_ctrl.sv
// Board state controller: the single writer of the 10x10 battleship board, serialising
// clear, ship-placement and shot requests onto the cell status array seen by the renderer.
module board_state_ctrl #(
    parameter int GRID_N  = 10,
    parameter int MAX_LEN = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear_req,
    input  logic                         place_req,
    input  logic [3:0]                   place_row,
    input  logic [3:0]                   place_col,
    input  logic [2:0]                   place_len,
    input  logic                         place_vert,
    output logic                         place_ack,
    output logic                         place_ok,
    input  logic                         fire_req,
    input  logic [3:0]                   fire_row,
    input  logic [3:0]                   fire_col,
    output logic                         fire_ack,
    output logic [1:0]                   fire_result,
    output logic [2*GRID_N*GRID_N-1:0]   cell_status_flat,
    output logic [6:0]                   ship_cells_left,
    output logic                         game_over,
    output logic                         busy
);
    localparam int         CELLS       = GRID_N * GRID_N;
    localparam logic [1:0] ST_EMPTY    = 2'b00;
    localparam logic [1:0] ST_SHIP     = 2'b01;
    localparam logic [1:0] ST_MISS     = 2'b10;
    localparam logic [1:0] ST_HIT      = 2'b11;
    localparam logic [1:0] RES_INVALID = 2'b00;
    localparam logic [1:0] RES_MISS    = 2'b01;
    localparam logic [1:0] RES_HIT     = 2'b10;
    localparam logic [1:0] RES_REPEAT  = 2'b11;
    localparam logic [7:0] ROW_STRIDE  = 8'(GRID_N);
    localparam logic [4:0] EDGE_LIMIT  = 5'(GRID_N);
    localparam logic [3:0] COORD_LIMIT = 4'(GRID_N);
    localparam logic [2:0] LEN_LIMIT   = 3'(MAX_LEN);
    localparam logic [6:0] LAST_CELL   = 7'(CELLS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_PCHK, S_PSCAN, S_PWRITE, S_PDONE, S_FIRE, S_FDONE
    } state_t;

    state_t                 state_r, state_s;
    logic [2*CELLS-1:0]     cells_r;
    logic                   clear_pend_r, prio_fire_r, ok_r;
    logic [2:0]             k_r, p_len_r;
    logic [6:0]             clr_idx_r, left_r;
    logic [3:0]             p_row_r, p_col_r, f_row_r, f_col_r;
    logic                   p_vert_r, over_r;
    logic [1:0]             res_r, fire_result_r;
    logic                   place_ack_r, place_ok_r, fire_ack_r, busy_r;

    logic                   place_go_s, fire_go_s, place_bad_s, last_k_s, fire_in_s;
    logic [7:0]             scan_idx_s, fire_idx_s;
    logic [1:0]             scan_cell_s, fire_cell_s, fire_res_s;

    // 8-bit linear cell index so row*GRID_N+col cannot overflow for any 4-bit coordinate
    function automatic logic [7:0] cell_index(input logic [3:0] row, input logic [3:0] col);
        return {4'd0, row} * ROW_STRIDE + {4'd0, col};
    endfunction

    // Request qualification, placement checks and fire classification
    always_comb begin
        place_go_s  = place_req && !place_ack_r;
        fire_go_s   = fire_req && !fire_ack_r;
        place_bad_s = (p_len_r == 3'd0) || (p_len_r > LEN_LIMIT) ||
                      (p_row_r >= COORD_LIMIT) || (p_col_r >= COORD_LIMIT) || over_r ||
                      (p_vert_r ? ({1'b0, p_row_r} + {2'b00, p_len_r} > EDGE_LIMIT)
                                : ({1'b0, p_col_r} + {2'b00, p_len_r} > EDGE_LIMIT));
        last_k_s    = (k_r == p_len_r - 3'd1);
        scan_idx_s  = cell_index(p_row_r, p_col_r) +
                      (p_vert_r ? ROW_STRIDE : 8'd1) * {5'd0, k_r};
        scan_cell_s = cells_r[{scan_idx_s, 1'b0} +: 2];
        fire_idx_s  = cell_index(f_row_r, f_col_r);
        fire_in_s   = (f_row_r < COORD_LIMIT) && (f_col_r < COORD_LIMIT);
        if (fire_in_s) begin
            fire_cell_s = cells_r[{fire_idx_s, 1'b0} +: 2];
        end else begin
            fire_cell_s = ST_EMPTY;
        end
        if (!fire_in_s || over_r) begin
            fire_res_s = RES_INVALID;
        end else begin
            case (fire_cell_s)
                ST_EMPTY: fire_res_s = RES_MISS;
                ST_SHIP:  fire_res_s = RES_HIT;
                default:  fire_res_s = RES_REPEAT;
            endcase
        end
    end

    // Next-state logic: pending clear first, then round-robin between fire and place
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (clear_pend_r) begin
                    state_s = S_CLR;
                end else if (fire_go_s && (!place_go_s || prio_fire_r)) begin
                    state_s = S_FIRE;
                end else if (place_go_s) begin
                    state_s = S_PCHK;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CLR: begin
                if (clr_idx_r == LAST_CELL) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_CLR;
                end
            end
            S_PCHK: begin
                if (place_bad_s) begin
                    state_s = S_PDONE;
                end else begin
                    state_s = S_PSCAN;
                end
            end
            S_PSCAN: begin
                if (scan_cell_s != ST_EMPTY) begin
                    state_s = S_PDONE;
                end else if (last_k_s) begin
                    state_s = S_PWRITE;
                end else begin
                    state_s = S_PSCAN;
                end
            end
            S_PWRITE: begin
                if (last_k_s) begin
                    state_s = S_PDONE;
                end else begin
                    state_s = S_PWRITE;
                end
            end
            S_PDONE: state_s = S_IDLE;
            S_FIRE:  state_s = S_FDONE;
            S_FDONE: state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Board array, counters, latched request fields and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cells_r       <= '0;
            clear_pend_r  <= 1'b0;
            prio_fire_r   <= 1'b1;
            ok_r          <= 1'b0;
            k_r           <= 3'd0;
            clr_idx_r     <= 7'd0;
            p_row_r       <= 4'd0;
            p_col_r       <= 4'd0;
            p_len_r       <= 3'd0;
            p_vert_r      <= 1'b0;
            f_row_r       <= 4'd0;
            f_col_r       <= 4'd0;
            left_r        <= 7'd0;
            over_r        <= 1'b0;
            res_r         <= 2'b00;
            fire_result_r <= 2'b00;
            place_ack_r   <= 1'b0;
            place_ok_r    <= 1'b0;
            fire_ack_r    <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            place_ack_r <= 1'b0;
            fire_ack_r  <= 1'b0;
            busy_r      <= (state_s != S_IDLE);
            if (clear_req) begin
                clear_pend_r <= 1'b1;
            end else if (state_r == S_CLR && clr_idx_r == LAST_CELL) begin
                clear_pend_r <= 1'b0;
            end
            case (state_r)
                S_IDLE: begin
                    if (state_s == S_PCHK) begin
                        p_row_r     <= place_row;
                        p_col_r     <= place_col;
                        p_len_r     <= place_len;
                        p_vert_r    <= place_vert;
                        prio_fire_r <= 1'b1;
                        ok_r        <= 1'b0;
                        k_r         <= 3'd0;
                    end else if (state_s == S_FIRE) begin
                        f_row_r     <= fire_row;
                        f_col_r     <= fire_col;
                        prio_fire_r <= 1'b0;
                    end else if (state_s == S_CLR) begin
                        clr_idx_r   <= 7'd0;
                    end
                end
                S_CLR: begin
                    cells_r[{clr_idx_r, 1'b0} +: 2] <= ST_EMPTY;
                    clr_idx_r <= clr_idx_r + 7'd1;
                    if (clr_idx_r == LAST_CELL) begin
                        left_r <= 7'd0;
                        over_r <= 1'b0;
                    end
                end
                S_PCHK:  k_r <= 3'd0;
                S_PSCAN: begin
                    if (state_s == S_PWRITE) begin
                        k_r <= 3'd0;
                    end else begin
                        k_r <= k_r + 3'd1;
                    end
                end
                S_PWRITE: begin
                    cells_r[{scan_idx_s, 1'b0} +: 2] <= ST_SHIP;
                    left_r <= left_r + 7'd1;
                    k_r    <= k_r + 3'd1;
                    if (last_k_s) begin
                        ok_r <= 1'b1;
                    end
                end
                S_PDONE: begin
                    place_ack_r <= 1'b1;
                    place_ok_r  <= ok_r;
                end
                S_FIRE: begin
                    res_r <= fire_res_s;
                    if (fire_res_s == RES_MISS) begin
                        cells_r[{fire_idx_s, 1'b0} +: 2] <= ST_MISS;
                    end else if (fire_res_s == RES_HIT) begin
                        cells_r[{fire_idx_s, 1'b0} +: 2] <= ST_HIT;
                        left_r <= left_r - 7'd1;
                        if (left_r == 7'd1) begin
                            over_r <= 1'b1;
                        end
                    end
                end
                S_FDONE: begin
                    fire_ack_r    <= 1'b1;
                    fire_result_r <= res_r;
                end
                default: k_r <= k_r;
            endcase
        end
    end

    assign place_ack        = place_ack_r;
    assign place_ok         = place_ok_r;
    assign fire_ack         = fire_ack_r;
    assign fire_result      = fire_result_r;
    assign cell_status_flat = cells_r;
    assign ship_cells_left  = left_r;
    assign game_over        = over_r;
    assign busy             = busy_r;

endmodule

// File: tb/tb_board_state_ctrl.sv
// Self-checking bench for board_state_ctrl: transaction-level board model, per-cycle
// compare of the idle outputs, directed scenarios with literal pins, then random traffic.
module tb_board_state_ctrl;
    logic         clk = 1'b0, reset = 1'b1, clear_req = 1'b0;
    logic         place_req = 1'b0, place_vert = 1'b0, fire_req = 1'b0;
    logic [3:0]   place_row = 4'd0, place_col = 4'd0, fire_row = 4'd0, fire_col = 4'd0;
    logic [2:0]   place_len = 3'd0;
    logic         place_ack, place_ok, fire_ack, game_over, busy;
    logic [1:0]   fire_result;
    logic [199:0] cell_status_flat;
    logic [6:0]   ship_cells_left;

    int checks = 0, errors = 0;
    int mb[100];
    int m_left = 0, m_res = 0;
    bit m_over = 0, m_ok = 0, m_prio_fire = 1, chk_en = 0;

    board_state_ctrl dut (
        .clk(clk), .reset(reset), .clear_req(clear_req),
        .place_req(place_req), .place_row(place_row), .place_col(place_col),
        .place_len(place_len), .place_vert(place_vert), .place_ack(place_ack), .place_ok(place_ok),
        .fire_req(fire_req), .fire_row(fire_row), .fire_col(fire_col),
        .fire_ack(fire_ack), .fire_result(fire_result),
        .cell_status_flat(cell_status_flat), .ship_cells_left(ship_cells_left),
        .game_over(game_over), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [199:0] model_flat();
        logic [199:0] f;
        for (int i = 0; i < 100; i++) f[2*i +: 2] = 2'(mb[i]);
        return f;
    endfunction

    task automatic model_reset();
        foreach (mb[i]) mb[i] = 0;
        m_left = 0; m_over = 0; m_ok = 0; m_res = 0; m_prio_fire = 1;
    endtask

    task automatic model_place(input int r, input int c, input int l, input bit v,
                               output int lat, output bit ok);
        int cells[$];
        ok = 1'b0;
        if (l == 0 || l > 5 || r > 9 || c > 9 || m_over || (v ? r + l > 10 : c + l > 10)) begin
            lat = 2;
            return;
        end
        for (int k = 0; k < l; k++) begin
            int i;
            i = v ? (r + k) * 10 + c : r * 10 + c + k;
            if (mb[i] != 0) begin
                lat = 3 + k;
                return;
            end
            cells.push_back(i);
        end
        foreach (cells[j]) mb[cells[j]] = 1;
        m_left += l;
        ok = 1'b1;
        lat = 2 * l + 2;
    endtask

    task automatic model_fire(input int r, input int c, output int res);
        if (r > 9 || c > 9 || m_over) begin
            res = 0;
        end else begin
            int i;
            i = r * 10 + c;
            case (mb[i])
                0: begin mb[i] = 2; res = 1; end
                1: begin
                    mb[i] = 3; res = 2; m_left--;
                    if (m_left == 0) m_over = 1;
                end
                default: res = 3;
            endcase
        end
    endtask

    // Per-cycle compare of the quiescent outputs against the model
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            check("flat", cell_status_flat, model_flat());
            check("left", 200'(ship_cells_left), 200'(m_left));
            check("game_over", 200'(game_over), 200'(m_over));
            check("busy_idle", 200'(busy), 200'(0));
            check("place_ok_hold", 200'(place_ok), 200'(m_ok));
            check("fire_res_hold", 200'(fire_result), 200'(m_res));
            check("acks_idle", 200'({place_ack, fire_ack}), 200'(0));
        end
    end

    task automatic do_place(input int r, input int c, input int l, input bit v, input int clr_at,
                            output int lat, output bit ok);
        int n, elat;
        bit eok;
        @(negedge clk);
        chk_en = 0;
        place_row = 4'(r); place_col = 4'(c); place_len = 3'(l); place_vert = v; place_req = 1;
        model_place(r, c, l, v, elat, eok);
        m_prio_fire = 1;
        lat = -1; ok = 0; n = 0;
        while (n < 400) begin
            @(posedge clk); n++;
            @(negedge clk);
            clear_req = (clr_at != 0 && n - 1 == clr_at);
            if (place_ack) begin
                lat = n - 1; ok = place_ok;
                break;
            end
        end
        place_req = 0; clear_req = 0;
        check("place_lat", 200'(lat), 200'(elat));
        check("place_ok", 200'(ok), 200'(eok));
        m_ok = eok;
        chk_en = (clr_at == 0);
    endtask

    task automatic do_fire(input int r, input int c, output int res);
        int n, lat, eres;
        @(negedge clk);
        chk_en = 0;
        fire_row = 4'(r); fire_col = 4'(c); fire_req = 1;
        model_fire(r, c, eres);
        m_prio_fire = 0;
        lat = -1; res = -1; n = 0;
        while (n < 400) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (fire_ack) begin
                lat = n - 1; res = fire_result;
                break;
            end
        end
        fire_req = 0;
        check("fire_lat", 200'(lat), 200'(2));
        check("fire_res", 200'(res), 200'(eres));
        m_res = eres;
        chk_en = 1;
    endtask

    task automatic do_both(input int fr, input int fc, input int pr, input int pc, input int pl,
                           input bit pv, output int tf, output int fres, output int tp, output bit pok);
        int lp, ef, n;
        bit eok, fire_first;
        @(negedge clk);
        chk_en = 0;
        fire_row = 4'(fr); fire_col = 4'(fc); fire_req = 1;
        place_row = 4'(pr); place_col = 4'(pc); place_len = 3'(pl); place_vert = pv; place_req = 1;
        fire_first = m_prio_fire;
        if (fire_first) begin
            model_fire(fr, fc, ef); model_place(pr, pc, pl, pv, lp, eok);
        end else begin
            model_place(pr, pc, pl, pv, lp, eok); model_fire(fr, fc, ef);
        end
        tf = -1; tp = -1; fres = -1; pok = 0; n = 0;
        while (n < 400 && (tf < 0 || tp < 0)) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (fire_ack) begin tf = n - 1; fres = fire_result; fire_req = 0; end
            if (place_ack) begin tp = n - 1; pok = place_ok; place_req = 0; end
        end
        fire_req = 0; place_req = 0;
        if (fire_first) begin
            check("both_fire_t", 200'(tf), 200'(2));
            check("both_place_t", 200'(tp), 200'(3 + lp));
        end else begin
            check("both_place_t", 200'(tp), 200'(lp));
            check("both_fire_t", 200'(tf), 200'(lp + 3));
        end
        check("both_fire_res", 200'(fres), 200'(ef));
        check("both_place_ok", 200'(pok), 200'(eok));
        m_prio_fire = fire_first; m_res = ef; m_ok = eok;
        chk_en = 1;
    endtask

    task automatic wait_clr(output int nb);
        int w;
        w = 0; nb = 0;
        while (!busy && w < 5) begin @(negedge clk); w++; end
        while (busy && nb < 300) begin nb++; @(negedge clk); end
        foreach (mb[i]) mb[i] = 0;
        m_left = 0; m_over = 0;
        chk_en = 1;
    endtask

    task automatic do_clear(output int nb);
        @(negedge clk);
        chk_en = 0; clear_req = 1;
        @(negedge clk);
        clear_req = 0;
        wait_clr(nb);
        check("clr_cycles", 200'(nb), 200'(100));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tf, tp, res, lat, nb, w;
        bit ok;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_flat", cell_status_flat, '0);
        check("rst_outs", 200'({place_ack, place_ok, fire_ack, fire_result, game_over, busy}), 200'(0));
        check("rst_left", 200'(ship_cells_left), 200'(0));
        reset = 0;
        chk_en = 1;

        // Simultaneous fire and place from reset: fire wins, place follows
        do_both(0, 0, 2, 3, 3, 0, tf, res, tp, ok);
        check("pin_both_tf", 200'(tf), 200'(2));
        check("pin_both_res", 200'(res), 200'(1));
        check("pin_both_tp", 200'(tp), 200'(11));
        check("pin_both_ok", 200'(ok), 200'(1));
        check("pin_cells_23_25", 200'(cell_status_flat[51:46]), 200'(6'b010101));
        check("pin_left3", 200'(ship_cells_left), 200'(3));

        do_place(2, 8, 3, 0, 0, lat, ok);
        check("pin_bounds_lat", 200'(lat), 200'(2));
        check("pin_bounds_ok", 200'(ok), 200'(0));
        do_place(1, 4, 3, 1, 0, lat, ok);
        check("pin_overlap_lat", 200'(lat), 200'(4));
        check("pin_overlap_ok", 200'(ok), 200'(0));
        check("pin_cell4", 200'(cell_status_flat[9:8]), 200'(0));

        do_fire(2, 4, res);
        check("pin_hit", 200'(res), 200'(2));
        check("pin_cell24", 200'(cell_status_flat[49:48]), 200'(3));
        check("pin_left2", 200'(ship_cells_left), 200'(2));
        do_fire(2, 4, res);
        check("pin_repeat", 200'(res), 200'(3));
        do_fire(9, 9, res);
        check("pin_miss", 200'(res), 200'(1));
        check("pin_cell99", 200'(cell_status_flat[199:198]), 200'(2));
        do_fire(10, 0, res);
        check("pin_invalid", 200'(res), 200'(0));
        do_fire(2, 3, res);
        do_fire(2, 5, res);
        check("pin_last_hit", 200'(res), 200'(2));
        check("pin_over", 200'(game_over), 200'(1));
        check("pin_left0", 200'(ship_cells_left), 200'(0));
        do_place(4, 4, 2, 0, 0, lat, ok);
        check("pin_over_place", 200'(ok), 200'(0));

        do_clear(nb);
        check("pin_clr_over", 200'(game_over), 200'(0));

        // Clear requested while the ship is being written
        do_place(0, 0, 5, 1, 6, lat, ok);
        check("pin_pw_lat", 200'(lat), 200'(12));
        check("pin_pw_ok", 200'(ok), 200'(1));
        wait_clr(nb);
        check("pin_pw_clr_cycles", 200'(nb), 200'(100));
        check("pin_pw_flat", cell_status_flat, '0);

        // Reset in the middle of a clear
        do_place(7, 0, 4, 0, 0, lat, ok);
        @(negedge clk);
        chk_en = 0; clear_req = 1;
        @(negedge clk);
        clear_req = 0;
        w = 0;
        while (!busy && w < 5) begin @(negedge clk); w++; end
        check("abort_busy", 200'(busy), 200'(1));
        repeat (50) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("abort_flat", cell_status_flat, '0);
        check("abort_outs", 200'({place_ack, place_ok, fire_ack, fire_result, game_over, busy}), 200'(0));
        check("abort_left", 200'(ship_cells_left), 200'(0));
        model_reset();
        chk_en = 1;

        for (int it = 0; it < 150; it++) begin
            int op;
            op = $urandom_range(0, 19);
            if (op == 0) begin
                do_clear(nb);
            end else if (op <= 3) begin
                do_both($urandom_range(0, 10), $urandom_range(0, 10), $urandom_range(0, 10),
                        $urandom_range(0, 10), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                        tf, res, tp, ok);
            end else if (op <= 11) begin
                do_place($urandom_range(0, 10), $urandom_range(0, 10), $urandom_range(0, 7),
                         1'($urandom_range(0, 1)), 0, lat, ok);
            end else begin
                do_fire($urandom_range(0, 10), $urandom_range(0, 10), res);
            end
        end

        @(negedge clk);
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
